mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Arbitrates one single-port unified memory between the IF-stage instruction fetch and the MEM-stage load/store.
//  Sits between IFStage/MEMStage and the memory macro.
//  Generates the freeze signals that hold the pipeline while a requester waits or its access is in flight.
//  The MEM stage has priority because it holds the older instruction.
// PARAMETERS
//  ADDR_W       32  memory address width (bits)
//  DATA_W       32  data width, equal to `WORD_LEN
//  TIMEOUT      15  max cycles to wait for ram_ready before aborting an access; 1..255
//  MAX_MEM_RUN   4  consecutive MEM grants allowed while IF waits (ARB_FAIRNESS_EN only); 1..15
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous reset, active-low
//  if_req     in   1       fetch request; level, held until if_done
//  if_addr    in   ADDR_W  fetch address (PC)
//  if_rdata   out  DATA_W  fetched instruction; valid while if_done=1
//  if_done    out  1       one-cycle pulse: fetch complete
//  mem_rd     in   1       load request; level, held until mem_done
//  mem_wr     in   1       store request; level; mem_rd and mem_wr are never both 1
//  mem_addr   in   ADDR_W  load/store address (ALU result)
//  mem_wdata  in   DATA_W  store data
//  mem_rdata  out  DATA_W  load data; valid while mem_done=1
//  mem_done   out  1       one-cycle pulse: load/store complete
//  ram_en     out  1       memory access strobe, held for the whole access
//  ram_we     out  1       write enable, qualified by ram_en
//  ram_addr   out  ADDR_W  memory address
//  ram_wdata  out  DATA_W  memory write data
//  ram_rdata  in   DATA_W  memory read data; sampled in the cycle ram_ready=1
//  ram_ready  in   1       memory completes the access this cycle
//  freeze_if  out  1       hold PC and IF2ID: if_req & ~if_done, or MEM access pending/active
//  freeze_pipe out 1       hold ID2EXE, EXE2MEM and MEM2WB: (mem_rd|mem_wr) & ~mem_done
//  err_timeout out 1       sticky: an access aborted on timeout; cleared only by reset
// BEHAVIOUR
//  - Reset (rst=0, asynchronous) values:
//    - state=IDLE, wait counter=0, run counter=0
//    - all outputs 0, including the rdata registers and err_timeout
//    - An access in progress is abandoned with no done pulse. ram_en drops together with reset.
//  - FSM states: IDLE, ACC_IF, ACC_MEM, DONE.
//  - IDLE:
//    - mem_rd|mem_wr -> ACC_MEM; else if_req -> ACC_IF; else stay.
//    - The grant decision is made combinationally from the requests in IDLE.
//    - ram_* are registered and asserted from the next cycle on.
//  - ACC_x:
//    - ram_en=1. ram_addr/ram_wdata/ram_we are latched at grant and stay stable even if the requester's inputs change.
//    - ram_we=1 only for a mem_wr grant.
//    - The wait counter increments every cycle.
//    - ram_ready=1 -> capture ram_rdata into if_rdata or mem_rdata, deassert ram_en, go to DONE.
//    - The minimum access is 1 cycle: ready in the first ACC cycle gives done 2 cycles after grant.
//  - DONE:
//    - For exactly one cycle, the matching done output = 1 and rdata holds the captured value.
//    - Then IDLE. No new grant is made in DONE, which gives the requester one cycle to drop or advance its request.
//  - Timeout:
//    - The wait counter reaches TIMEOUT with no ram_ready -> go to DONE with rdata = 0 and set err_timeout.
//    - The done pulse still fires, so the pipeline never deadlocks.
//  - Simultaneous events:
//    - IF and MEM both requesting in IDLE -> MEM wins (unless the fairness override applies).
//    - ram_ready in the same cycle as the timeout -> ready wins and err_timeout is not set.
//  - Request dropped mid-access: the access completes and the done pulse is still issued; the requester ignores it.
//  - A store is acknowledged only on ram_ready. Read data is not forwarded combinationally.
// CONFIGURATION
//  - ARB_FAIRNESS_EN defined:
//    - A 4-bit run counter counts consecutive MEM grants made while if_req=1.
//    - When the counter = MAX_MEM_RUN and both requesters are pending, IF is granted and the counter resets to 0.
//    - The counter also resets whenever IF is granted or if_req=0 at a grant.
//  - ARB_FAIRNESS_EN undefined: strict MEM priority, and no run counter is built.
// TESTING
//  1. Reset mid-access: rst=0 during ACC_MEM -> all outputs 0 immediately; after release, no stale done pulse.
//  2. Lone fetch:
//     - Stimulus: if_req=1, if_addr=0x10, ram_ready 1 cycle after ram_en, ram_rdata=0xDEADBEEF.
//     - Response: if_done pulses 1 cycle with if_rdata=0xDEADBEEF; ram_we=0 throughout; freeze_if=0 in the cycle after done.
//  3. Contention:
//     - Stimulus: if_req=1 and mem_wr=1 (addr 0x40, data 0x5A5A5A5A) in the same cycle.
//     - Response: the store is granted first with ram_we=1 and ram_addr=0x40; mem_done pulses; then the fetch is granted; freeze_pipe=1 until mem_done.
//  4. Timeout:
//     - Stimulus: mem_rd=1, ram_ready held 0.
//     - Response: mem_done pulses exactly TIMEOUT+1 cycles after ram_en rises, mem_rdata=0, err_timeout=1 and remains 1.
//  5. Latch stability: change mem_addr 0x40->0x80 during ACC_MEM -> ram_addr stays 0x40 until the access ends.
//  6. Fairness (ARB_FAIRNESS_EN, MAX_MEM_RUN=4):
//     - Stimulus: mem_rd and if_req both continuously high.
//     - Response: grant order MEM,MEM,MEM,MEM,IF,MEM,...
//     - Without the macro: IF is never granted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between IF fetch and MEM load/store, with pipeline freeze generation.
// Optional ARB_FAIRNESS_EN: after MAX_MEM_RUN back-to-back MEM grants with IF waiting, IF gets one grant.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT     = 15,
  parameter int unsigned MAX_MEM_RUN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready,
  output logic              freeze_if,
  output logic              freeze_pipe,
  output logic              err_timeout
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned RUN_W = 4;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  // Elaboration-time guard on the supported parameter ranges.
  if (TIMEOUT == 0 || TIMEOUT > 255 || MAX_MEM_RUN == 0 || MAX_MEM_RUN > 15) begin : g_bad_param
    $error("mem_port_arbiter: TIMEOUT or MAX_MEM_RUN out of range");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACC_IF  = 2'd1,
    ACC_MEM = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_req;
  logic             fair_turn_c;
  logic             grant_mem_c;
  logic             grant_if_c;

  assign mem_req = mem_rd | mem_wr;

`ifdef ARB_FAIRNESS_EN
  logic [RUN_W-1:0] run_cnt;

  assign fair_turn_c = (run_cnt == RUN_W'(MAX_MEM_RUN)) & if_req & mem_req;

  // Consecutive MEM grants taken while IF was waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt <= '0;
    end else if (grant_if_c || (grant_mem_c && !if_req)) begin
      run_cnt <= '0;
    end else if (grant_mem_c && run_cnt != '1) begin
      run_cnt <= run_cnt + RUN_W'(1);
    end
  end
`else
  assign fair_turn_c = 1'b0;
`endif

  // Grant decision, only meaningful while idle; MEM holds the older instruction.
  always_comb begin
    grant_mem_c = 1'b0;
    grant_if_c  = 1'b0;
    if (state == IDLE) begin
      if (mem_req && !fair_turn_c) begin
        grant_mem_c = 1'b1;
      end else if (if_req) begin
        grant_if_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      if_rdata    <= '0;
      mem_rdata   <= '0;
      if_done     <= 1'b0;
      mem_done    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (grant_mem_c) begin
            state     <= ACC_MEM;
            ram_en    <= 1'b1;
            ram_we    <= mem_wr;
            ram_addr  <= mem_addr;
            ram_wdata <= mem_wdata;
          end else if (grant_if_c) begin
            state    <= ACC_IF;
            ram_en   <= 1'b1;
            ram_we   <= 1'b0;
            ram_addr <= if_addr;
          end
        end
        ACC_IF, ACC_MEM: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          // Ready in the last allowed cycle still counts as a normal completion.
          if (ram_ready || wait_cnt == TIMEOUT_CNT) begin
            state  <= DONE;
            ram_en <= 1'b0;
            ram_we <= 1'b0;
            if (state == ACC_IF) begin
              if_done  <= 1'b1;
              if_rdata <= ram_ready ? ram_rdata : '0;
            end else begin
              mem_done  <= 1'b1;
              mem_rdata <= ram_ready ? ram_rdata : '0;
            end
            if (!ram_ready) begin
              err_timeout <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Freezes follow the live requests so the pipeline releases in the done cycle itself.
  assign freeze_pipe = rst & mem_req & ~mem_done;
  assign freeze_if   = rst & ((if_req & ~if_done) | (mem_req & ~mem_done) | (state == ACC_MEM));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level timing model.
// Honours ARB_FAIRNESS_EN in the reference model when the macro is defined.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned TIMEOUT     = 15;
  localparam int unsigned MAX_MEM_RUN = 4;
  localparam int          N_CYC       = 3000;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ready;
  logic              freeze_if;
  logic              freeze_pipe;
  logic              err_timeout;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .TIMEOUT    (TIMEOUT),
    .MAX_MEM_RUN(MAX_MEM_RUN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_done    (if_done),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_done   (mem_done),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .ram_ready  (ram_ready),
    .freeze_if  (freeze_if),
    .freeze_pipe(freeze_pipe),
    .err_timeout(err_timeout)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic zero_outputs(input string tag);
    check({tag, ":ram_en"},      64'(ram_en),      64'd0);
    check({tag, ":ram_we"},      64'(ram_we),      64'd0);
    check({tag, ":ram_addr"},    64'(ram_addr),    64'd0);
    check({tag, ":ram_wdata"},   64'(ram_wdata),   64'd0);
    check({tag, ":if_rdata"},    64'(if_rdata),    64'd0);
    check({tag, ":mem_rdata"},   64'(mem_rdata),   64'd0);
    check({tag, ":if_done"},     64'(if_done),     64'd0);
    check({tag, ":mem_done"},    64'(mem_done),    64'd0);
    check({tag, ":err_timeout"}, 64'(err_timeout), 64'd0);
    check({tag, ":freeze_if"},   64'(freeze_if),   64'd0);
    check({tag, ":freeze_pipe"}, 64'(freeze_pipe), 64'd0);
  endtask

  // Memory contents as seen by the bench: completed stores, else an address hash.
  logic [31:0] mem_arr [logic [31:0]];

  function automatic logic [31:0] stored(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, 15)) << 2;
  endfunction

  // Current access record: granted at input slot a_j, a_d extra cycles until ready/timeout.
  bit          a_valid, a_mem, a_we, a_to;
  int          a_j, a_d, a_l;
  logic [31:0] a_addr, a_wdata, a_rdata;
  int          free_slot;
  bit          exp_err;
  int          run_m;
  bit          did_reset;
  int          p_raise, p_keep, p_drop, p_long;

  initial begin
    bit in_acc, at_done, x_if_done, x_mem_done, x_mem_act, mreq, give_if;
    int s, k;
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0;
    ram_rdata = '0; ram_ready = 1'b0;
    a_valid = 1'b0; exp_err = 1'b0; run_m = 0; did_reset = 1'b0;
    a_mem = 1'b0; a_we = 1'b0; a_to = 1'b0; a_j = 0; a_d = 0; a_l = 0;
    a_addr = '0; a_wdata = '0; a_rdata = '0;
    repeat (3) @(negedge clk);
    zero_outputs("reset");
    rst = 1'b1;
    free_slot = 1;
    cyc = 0;

    for (int it = 0; it < N_CYC; it++) begin
      @(negedge clk);
      cyc++;
      if (cyc < 1200) begin
        p_raise = 30; p_keep = 50; p_drop = 2; p_long = 10;
      end else if (cyc < 1700) begin
        p_raise = 100; p_keep = 100; p_drop = 0; p_long = 0;
      end else begin
        p_raise = 40; p_keep = 60; p_drop = 3; p_long = 15;
      end

      in_acc     = a_valid && cyc >= a_j && cyc <= a_j + a_d;
      at_done    = a_valid && cyc == a_j + a_d + 1;
      x_if_done  = at_done && !a_mem;
      x_mem_done = at_done && a_mem;
      x_mem_act  = in_acc && a_mem;
      if (at_done && a_to) exp_err = 1'b1;

      check("ram_en", 64'(ram_en), 64'(in_acc));
      if (in_acc) begin
        check("ram_we", 64'(ram_we), 64'(a_we));
        check("ram_addr", 64'(ram_addr), 64'(a_addr));
        if (a_we) check("ram_wdata", 64'(ram_wdata), 64'(a_wdata));
      end
      check("if_done", 64'(if_done), 64'(x_if_done));
      check("mem_done", 64'(mem_done), 64'(x_mem_done));
      if (x_if_done) check("if_rdata", 64'(if_rdata), 64'(a_to ? 32'd0 : a_rdata));
      if (x_mem_done) check("mem_rdata", 64'(mem_rdata), 64'(a_to ? 32'd0 : a_rdata));
      check("err_timeout", 64'(err_timeout), 64'(exp_err));
      if (at_done && a_we && !a_to) mem_arr[a_addr] = a_wdata;

      if (!did_reset && cyc >= 2200 && x_mem_act) begin
        // Abandon a MEM access with reset; no done may follow.
        did_reset = 1'b1;
        rst = 1'b0;
        #1;
        zero_outputs("rst_mid_acc");
        repeat (2) @(negedge clk);
        cyc += 2;
        rst = 1'b1;
        a_valid = 1'b0; exp_err = 1'b0; run_m = 0; free_slot = cyc + 1;
        x_if_done = 1'b0; x_mem_done = 1'b0; x_mem_act = 1'b0;
      end else begin
        // Fetch requester
        if (x_if_done) begin
          if ($urandom_range(0, 99) < p_keep) begin
            if_req = 1'b1; if_addr = if_addr + 32'd4;
          end else begin
            if_req = 1'b0;
          end
        end else if (!if_req) begin
          if ($urandom_range(0, 99) < p_raise) begin
            if_req = 1'b1; if_addr = rand_addr();
          end
        end else if ($urandom_range(0, 99) < p_drop) begin
          if_req = 1'b0;
        end else if ($urandom_range(0, 99) < 10) begin
          if_addr = rand_addr();
        end

        // Load/store requester
        mreq = mem_rd | mem_wr;
        if (x_mem_done || !mreq) begin
          mem_rd = 1'b0; mem_wr = 1'b0;
          if ($urandom_range(0, 99) < (x_mem_done ? p_keep : p_raise)) begin
            if (cyc >= 1200 && cyc < 1700) mem_rd = 1'b1;
            else if ($urandom_range(0, 1) == 1) mem_wr = 1'b1;
            else mem_rd = 1'b1;
            mem_addr = rand_addr(); mem_wdata = $urandom;
          end
        end else if ($urandom_range(0, 99) < p_drop) begin
          mem_rd = 1'b0; mem_wr = 1'b0;
        end else if ($urandom_range(0, 99) < 10) begin
          mem_addr = rand_addr(); mem_wdata = $urandom;
        end

        // Memory responder: ready exactly a_l cycles into the access, noise elsewhere
        s = cyc + 1;
        if (a_valid && s >= a_j + 1 && s <= a_j + 1 + a_d) begin
          k = s - a_j - 1;
          ram_ready = (k == a_l);
          ram_rdata = (k == a_l) ? a_rdata : $urandom;
        end else begin
          ram_ready = ($urandom_range(0, 3) == 0);
          ram_rdata = $urandom;
        end
      end

      // Arbitration for the inputs now on the pins
      s = cyc + 1;
      mreq = mem_rd | mem_wr;
      if (s >= free_slot && (mreq || if_req)) begin
        give_if = !mreq;
`ifdef ARB_FAIRNESS_EN
        if (mreq && if_req && run_m == int'(MAX_MEM_RUN)) give_if = 1'b1;
        if (give_if || !if_req) run_m = 0;
        else run_m++;
`endif
        a_valid = 1'b1;
        a_j     = s;
        a_mem   = !give_if;
        a_addr  = give_if ? if_addr : mem_addr;
        a_we    = !give_if && mem_wr;
        a_wdata = mem_wdata;
        a_rdata = a_we ? 32'($urandom) : stored(a_addr);
        if ($urandom_range(0, 99) < p_long) a_l = int'($urandom_range(TIMEOUT - 1, TIMEOUT + 2));
        else a_l = int'($urandom_range(0, 3));
        a_to = a_l > int'(TIMEOUT);
        a_d  = a_to ? int'(TIMEOUT) : a_l;
        free_slot = s + a_d + 3;
      end

      #1;
      check("freeze_pipe", 64'(freeze_pipe), 64'(mreq && !x_mem_done));
      check("freeze_if", 64'(freeze_if),
            64'((if_req && !x_if_done) || (mreq && !x_mem_done) || x_mem_act));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
